// File: rtl/mcs4_bus_tracer_if.sv
// Bus and record-stream bundle for mcs4_bus_tracer.
// slave: tracer side (snoops bus, sources records); master: system/consumer side.
interface mcs4_bus_tracer_if #(
    parameter int DEPTH = 16,
    parameter int N_CM  = 4,
    parameter int TS_W  = 16
) ();
    localparam int REC_W = 25 + N_CM + TS_W;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              PHI2_i;
    logic              SYNC_i;
    logic [3:0]        D_i;
    logic              CM_ROM_i;
    logic [N_CM-1:0]   CM_RAM_i;
    logic              en_i;
    logic              clr_i;
    logic              rec_valid_o;
    logic              rec_ready_i;
    logic [REC_W-1:0]  rec_data_o;
    logic [CW-1:0]     count_o;
    logic              overflow_o;
    logic              sync_err_o;
    logic [7:0]        drop_cnt_o;

    modport slave (
        input  PHI2_i, SYNC_i, D_i, CM_ROM_i, CM_RAM_i,
        input  en_i, clr_i, rec_ready_i,
        output rec_valid_o, rec_data_o, count_o,
        output overflow_o, sync_err_o, drop_cnt_o
    );

    modport master (
        output PHI2_i, SYNC_i, D_i, CM_ROM_i, CM_RAM_i,
        output en_i, clr_i, rec_ready_i,
        input  rec_valid_o, rec_data_o, count_o,
        input  overflow_o, sync_err_o, drop_cnt_o
    );
endinterface

// File: rtl/mcs4_bus_tracer.sv
// MCS-4 bus trace capture: follows the 8-phase cycle, builds one record per
// instruction cycle and queues it in a FWFT FIFO. Ports: clk_i, rst_i, bus (slave).
module mcs4_bus_tracer #(
    parameter int DEPTH    = 16,
    parameter int N_CM     = 4,
    parameter int TS_W     = 16,
    parameter bit SYNC_POL = 1'b1
) (
    input logic clk_i,
    input logic rst_i,
    mcs4_bus_tracer_if.slave bus
);
    localparam int REC_W = 25 + N_CM + TS_W;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;

    typedef enum logic [3:0] {
        S_UNSYNC, S_A1, S_A2, S_A3, S_M1, S_M2, S_X1, S_X2, S_X3
    } state_t;

    state_t            state_q, state_d;
    logic              phi2_q;
    logic [11:0]       addr_q, addr_d;
    logic [7:0]        op_q, op_d;
    logic [3:0]        x2_q, x2_d;
    logic [N_CM:0]     cm_q, cm_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              serr_q, serr_d;
    logic [7:0]        drop_q, drop_d;
    logic [REC_W-1:0]  mem_q [DEPTH];

    logic              step, sync_hit, x3_exit, err_set;
    logic              push_req, pop, full, wr, drop;
    logic [REC_W-1:0]  rec_new;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        op_d     = op_q;
        x2_d     = x2_q;
        cm_d     = cm_q;
        err_set  = 1'b0;
        x3_exit  = 1'b0;
        step     = phi2_q & ~bus.PHI2_i;
        sync_hit = step && (bus.SYNC_i == SYNC_POL);
        if (step) begin
            x3_exit = (state_q == S_X3);
            if (sync_hit) begin
                state_d = S_A1;
                // Sync anywhere but X3/UNSYNC aborts the partial record;
                // the fresh A1 overwrites its fields.
                err_set = (state_q != S_X3) && (state_q != S_UNSYNC);
            end else begin
                unique case (state_q)
                    S_UNSYNC: state_d = S_UNSYNC;
                    S_A1: begin state_d = S_A2; addr_d[3:0]  = bus.D_i; end
                    S_A2: begin state_d = S_A3; addr_d[7:4]  = bus.D_i; end
                    S_A3: begin state_d = S_M1; addr_d[11:8] = bus.D_i; end
                    S_M1: begin state_d = S_M2; op_d[7:4]    = bus.D_i; end
                    S_M2: begin state_d = S_X1; op_d[3:0]    = bus.D_i; end
                    S_X1: state_d = S_X2;
                    S_X2: begin
                        state_d = S_X3;
                        x2_d    = bus.D_i;
                        cm_d    = {bus.CM_RAM_i, bus.CM_ROM_i};
                    end
                    S_X3: state_d = S_A1;
                    default: state_d = S_UNSYNC;
                endcase
            end
        end
    end

    // Only reachable X3 states have walked A1..X2, so X3 exit means complete.
    assign rec_new  = {ts_q, cm_q, x2_q, op_q, addr_q};
    assign push_req = x3_exit & bus.en_i;
    assign pop      = (count_q != '0) & bus.rec_ready_i;
    assign full     = (count_q == CW'(DEPTH));
    assign wr       = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        ts_d     = ts_q + TS_W'(x3_exit);
        wr_ptr_d = wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr) - CW'(pop);
        ovf_d    = (ovf_q & ~bus.clr_i) | drop;
        serr_d   = (serr_q & ~bus.clr_i) | err_set;
        drop_d   = bus.clr_i ? 8'd0 : drop_q;
        if (drop && drop_d != 8'hFF) begin
            drop_d = drop_d + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_UNSYNC;
            phi2_q   <= 1'b0;
            addr_q   <= '0;
            op_q     <= '0;
            x2_q     <= '0;
            cm_q     <= '0;
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            serr_q   <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            phi2_q   <= bus.PHI2_i;
            addr_q   <= addr_d;
            op_q     <= op_d;
            x2_q     <= x2_d;
            cm_q     <= cm_d;
            ts_q     <= ts_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            serr_q   <= serr_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= rec_new;
        end
    end

    assign bus.rec_valid_o = (count_q != '0);
    assign bus.rec_data_o  = bus.rec_valid_o ? mem_q[rd_ptr_q] : '0;
    assign bus.count_o     = count_q;
    assign bus.overflow_o  = ovf_q;
    assign bus.sync_err_o  = serr_q;
    assign bus.drop_cnt_o  = drop_q;
endmodule
